// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU op codes, arbitration pointer type and the illegal-op check
// used by the shared-ALU arbiter, its ALU and its testbench.
package alu_share_arbiter_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SUB  = 4'b1001,
    OP_SUBU = 4'b1010
  } alu_op_e;

  // Which requester wins when both are eligible.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  function automatic logic is_illegal_op(input logic [ALU_OP_W-1:0] op);
    return !(op inside {[OP_ADD:OP_SUBU]});
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters. Shifts operate on data2 by
// shamt; illegal codes yield result 0 with err set.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W,
  parameter int SH_W   = 5
) (
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [SH_W-1:0]   shamt_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              err_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = data1_i + data2_i;
      OP_AND:  result_o = data1_i & data2_i;
      OP_NOR:  result_o = ~(data1_i | data2_i);
      OP_OR:   result_o = data1_i | data2_i;
      OP_SLL:  result_o = data2_i << shamt_i;
      OP_SRL:  result_o = data2_i >> shamt_i;
      OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, (data1_i < data2_i)};
      OP_SUB:  result_o = data1_i - data2_i;
      OP_SUBU: result_o = data1_i - data2_i;
      default: result_o = '0;
    endcase
  end

  assign err_o  = is_illegal_op(op_i);
  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, with a
// registered one-entry response slot per requester (issue-to-result latency 1).
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = ALU_OP_W,
  parameter int SH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data1,
  input  logic [DATA_W-1:0] req0_data2,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [SH_W-1:0]   req0_shamt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data1,
  input  logic [DATA_W-1:0] req1_data2,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [SH_W-1:0]   req1_shamt,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_err
);

  prio_e                   prio_q, prio_d;
  logic [1:0]              slot_valid_q, slot_valid_d;
  logic [1:0][DATA_W-1:0]  slot_result_q, slot_result_d;
  logic [1:0]              slot_zero_q, slot_zero_d;
  logic [1:0]              slot_err_q, slot_err_d;

  logic [1:0]              req_valid, rsp_ready, elig, grant;
  logic [DATA_W-1:0]       alu_data1, alu_data2, alu_result;
  logic [OP_W-1:0]         alu_op;
  logic [SH_W-1:0]         alu_shamt;
  logic                    alu_zero, alu_err;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A full slot being drained this cycle can be refilled in the same cycle.
  assign elig = req_valid & (~slot_valid_q | rsp_ready);

  always_comb begin
    grant  = '0;
    prio_d = prio_q;
    if (rst_n) begin
      if (elig[0] && (!elig[1] || prio_q == PRIO_REQ0)) grant[0] = 1'b1;
      else if (elig[1])                                 grant[1] = 1'b1;
    end
    if (grant[0])      prio_d = PRIO_REQ1;
    else if (grant[1]) prio_d = PRIO_REQ0;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign alu_data1 = grant[1] ? req1_data1 : req0_data1;
  assign alu_data2 = grant[1] ? req1_data2 : req0_data2;
  assign alu_op    = grant[1] ? req1_op    : req0_op;
  assign alu_shamt = grant[1] ? req1_shamt : req0_shamt;

  alu_share_arbiter_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .SH_W   (SH_W)
  ) u_alu (
    .data1_i  (alu_data1),
    .data2_i  (alu_data2),
    .op_i     (alu_op),
    .shamt_i  (alu_shamt),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  always_comb begin
    slot_valid_d  = slot_valid_q;
    slot_result_d = slot_result_q;
    slot_zero_d   = slot_zero_q;
    slot_err_d    = slot_err_q;
    for (int n = 0; n < 2; n++) begin
      if (grant[n]) begin
        slot_valid_d[n]  = 1'b1;
        slot_result_d[n] = alu_result;
        slot_zero_d[n]   = alu_zero;
        slot_err_d[n]    = alu_err;
      end else if (rsp_ready[n]) begin
        slot_valid_d[n]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= PRIO_REQ0;
      slot_valid_q  <= '0;
      // NOTE: slot payload is reset too, since its reset value of zero is visible on the outputs.
      slot_result_q <= '0;
      slot_zero_q   <= '0;
      slot_err_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state samples pre-edge values together.
      prio_q        <= prio_d;
      slot_valid_q  <= slot_valid_d;
      slot_result_q <= slot_result_d;
      slot_zero_q   <= slot_zero_d;
      slot_err_q    <= slot_err_d;
    end
  end

  assign rsp0_valid  = slot_valid_q[0];
  assign rsp0_result = slot_result_q[0];
  assign rsp0_zero   = slot_zero_q[0];
  assign rsp0_err    = slot_err_q[0];
  assign rsp1_valid  = slot_valid_q[1];
  assign rsp1_result = slot_result_q[1];
  assign rsp1_zero   = slot_zero_q[1];
  assign rsp1_err    = slot_err_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single issue, round-robin,
// back-pressure with drain/refill, ALU op table, contention and mid-run reset.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;
  localparam int SH_W   = 5;

  localparam logic [31:0] OPA     = 32'h8155_5FCD;
  localparam logic [31:0] OPB     = 32'h0003_FFF0;
  localparam logic [31:0] ADD_RES = 32'h8159_5FBD;
  localparam logic [31:0] AND_RES = 32'h0001_5FC0;
  localparam logic [31:0] OR_RES  = 32'h8157_FFFD;

  logic              clk, rst_n;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_W-1:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [SH_W-1:0]   req0_shamt, req1_shamt;
  logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
  logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .SH_W(SH_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_op(req0_op), .req0_shamt(req0_shamt),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_op(req1_op), .req1_shamt(req1_shamt),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    req0_valid = 1'b0; req0_data1 = '0; req0_data2 = '0; req0_op = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_data1 = '0; req1_data2 = '0; req1_op = '0; req1_shamt = '0;
  endtask

  task automatic set_req0(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
    req0_valid = 1'b1; req0_op = op; req0_data1 = d1; req0_data2 = d2; req0_shamt = '0;
  endtask

  task automatic set_req1(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2);
    req1_valid = 1'b1; req1_op = op; req1_data1 = d1; req1_data2 = d2; req1_shamt = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp0_valid got=%b exp=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp1_valid got=%b exp=0", rsp1_valid); end
    checks++; if (rsp0_result !== 32'h0) begin failures++; $display("FAIL reset_rsp0_result got=%h exp=0", rsp0_result); end
    checks++; if (rsp1_result !== 32'h0) begin failures++; $display("FAIL reset_rsp1_result got=%h exp=0", rsp1_result); end
    checks++; if ({rsp0_zero, rsp0_err, rsp1_zero, rsp1_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", {req1_ready, req0_ready}); end
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_single_add();
    set_req0(OP_ADD, OPA, OPB);
    rsp0_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL add_ready got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL add_rsp_valid got=%b exp=1", rsp0_valid); end
    checks++; if (rsp0_result !== ADD_RES) begin failures++; $display("FAIL add_result got=%h exp=%h", rsp0_result, ADD_RES); end
    checks++; if ({rsp0_zero, rsp0_err} !== 2'b00) begin failures++; $display("FAIL add_flags got=%b exp=00", {rsp0_zero, rsp0_err}); end
    @(posedge clk); #1;
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_drain got=%b exp=0", rsp0_valid); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req0(OP_ADD, OPA, OPB);
    set_req1(OP_OR, OPA, OPB);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp0;
      exp0 = (i % 2 == 0);
      #1;
      checks++; if ({req1_ready, req0_ready} !== {~exp0, exp0}) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, {req1_ready, req0_ready}, {~exp0, exp0}); end
      @(posedge clk); #1;
      checks++; if ({rsp1_valid, rsp0_valid} !== {~exp0, exp0}) begin failures++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", i, {rsp1_valid, rsp0_valid}, {~exp0, exp0}); end
      if (exp0) begin
        checks++; if (rsp0_result !== ADD_RES) begin failures++; $display("FAIL rr_rsp0_result[%0d] got=%h exp=%h", i, rsp0_result, ADD_RES); end
      end else begin
        checks++; if (rsp1_result !== OR_RES) begin failures++; $display("FAIL rr_rsp1_result[%0d] got=%h exp=%h", i, rsp1_result, OR_RES); end
      end
      @(negedge clk);
    end
  endtask

  // Entered with slot1 full, slot0 empty, req0 next in line, both requesting.
  task automatic test_backpressure();
    rsp0_ready = 1'b0;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL bp_fill_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL bp_fill_valid got=%b exp=1", rsp0_valid); end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL bp_stall_grant[%0d] got=%b exp=10", k, {req1_ready, req0_ready}); end
      @(posedge clk); #1;
      checks++; if ({rsp1_valid, rsp0_valid} !== 2'b11) begin failures++; $display("FAIL bp_stall_valid[%0d] got=%b exp=11", k, {rsp1_valid, rsp0_valid}); end
      checks++; if (rsp0_result !== ADD_RES) begin failures++; $display("FAIL bp_stall_hold[%0d] got=%h exp=%h", k, rsp0_result, ADD_RES); end
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL bp_refill_grant got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin failures++; $display("FAIL bp_refill_valid got=%b exp=01", {rsp1_valid, rsp0_valid}); end
    @(negedge clk); #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL bp_after_grant got=%b exp=10", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b10) begin failures++; $display("FAIL bp_after_valid got=%b exp=10", {rsp1_valid, rsp0_valid}); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    vec_t vecs[9];
    vecs[0] = '{OP_SUB,  OPA, OPA, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{4'b1111, OPA, OPB, 5'd0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[2] = '{4'b0000, OPA, OPB, 5'd3, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{OP_SLT,  OPA, OPB, 5'd0, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4] = '{OP_SLTU, OPA, OPB, 5'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{OP_NOR,  OPA, OPB, 5'd0, 32'h7EA8_0002, 1'b0, 1'b0};
    vecs[6] = '{OP_SLL,  OPA, OPA, 5'd4, 32'h1555_FCD0, 1'b0, 1'b0};
    vecs[7] = '{OP_SRL,  OPA, OPA, 5'd4, 32'h0815_55FC, 1'b0, 1'b0};
    vecs[8] = '{OP_SUBU, OPB, OPA, 5'd0, 32'h7EAE_A023, 1'b0, 1'b0};
    rsp1_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_req1(vecs[i].op, vecs[i].d1, vecs[i].d2);
      req1_shamt = vecs[i].sh;
      #1;
      checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL op_ready[%0d] got=%b exp=1", i, req1_ready); end
      @(posedge clk); #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== vecs[i].res || rsp1_zero !== vecs[i].zero || rsp1_err !== vecs[i].err)
        begin failures++; $display("FAIL op_result[%0d] got=v%b r=%h z=%b e=%b exp=v1 r=%h z=%b e=%b", i, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err, vecs[i].res, vecs[i].zero, vecs[i].err); end
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);
  endtask

  // Entered with requester 1 granted last, so requester 0 wins first.
  task automatic test_contention();
    set_req0(OP_AND, OPA, OPB);
    set_req1(OP_OR, OPA, OPB);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL cont_grant0 got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_result !== AND_RES || rsp0_zero !== 1'b0) begin failures++; $display("FAIL cont_and got=v%b r=%h z=%b exp=v1 r=%h z=0", rsp0_valid, rsp0_result, rsp0_zero, AND_RES); end
    @(negedge clk); #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL cont_grant1 got=%b exp=10", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if (rsp1_valid !== 1'b1 || rsp1_result !== OR_RES || rsp0_valid !== 1'b0) begin failures++; $display("FAIL cont_or got=v1=%b r=%h v0=%b exp=v1=1 r=%h v0=0", rsp1_valid, rsp1_result, rsp0_valid, OR_RES); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set_req1(OP_ADD, OPA, OPB);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin failures++; $display("FAIL mid_fill1 got=%b exp=10", {req1_ready, req0_ready}); end
    @(negedge clk);
    set_req0(OP_AND, OPA, OPB);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL mid_fill0 got=%b exp=01", {req1_ready, req0_ready}); end
    @(posedge clk); #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b11) begin failures++; $display("FAIL mid_full got=%b exp=11", {rsp1_valid, rsp0_valid}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin failures++; $display("FAIL mid_async_clear got=%b exp=00", {rsp1_valid, rsp0_valid}); end
    checks++; if (rsp0_result !== 32'h0 || rsp1_result !== 32'h0) begin failures++; $display("FAIL mid_result_clear got=%h/%h exp=0/0", rsp0_result, rsp1_result); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready_in_reset got=%b exp=00", {req1_ready, req0_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL mid_first_grant got=%b exp=01", {req1_ready, req0_ready}); end
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin failures++; $display("FAIL mid_no_stale got=%b exp=00", {rsp1_valid, rsp0_valid}); end
    @(posedge clk); #1;
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b01 || rsp0_result !== AND_RES) begin failures++; $display("FAIL mid_after_release got=%b r=%h exp=01 r=%h", {rsp1_valid, rsp0_valid}, rsp0_result, AND_RES); end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_alu_ops();
    test_contention();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
